// File: rtl/debounce_stage_if.sv
// debounce_stage_if: raw input and debounced outputs of the debounce stage
interface debounce_stage_if #(
    parameter int CNT_W = 8
);
    logic             inp;
    logic             out;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] glitch_cnt;
    modport master (output inp, input out, rise, fall, glitch_cnt);
    modport slave (input inp, output out, rise, fall, glitch_cnt);
endinterface

// File: rtl/debounce_stage.sv
// debounce_stage: two-flop synchronizer plus persistence filter with edge pulses and glitch counter
module debounce_stage #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    debounce_stage_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {
        WAIT_HIGH   = 2'b00,
        STABLE_LOW  = 2'b01,
        WAIT_LOW    = 2'b10,
        STABLE_HIGH = 2'b11
    } state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             s1;
    logic             s2;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] gcnt;
    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
            $error("debounce_stage: STABLE_CYCLES must be in 1..255");
        end
    endgenerate
    // bring the asynchronous pad level into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.inp;
            s2 <= s1;
        end
    end
    // state bit 1 is the debounced level, bit 0 flags an idle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            gcnt  <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 != state[1]) begin
                if (cnt == LAST) begin
                    state <= s2 ? STABLE_HIGH : STABLE_LOW;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    state <= s2 ? WAIT_HIGH : WAIT_LOW;
                    cnt   <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                state <= s2 ? STABLE_HIGH : STABLE_LOW;
                cnt   <= '0;
                if (gcnt != '1) gcnt <= gcnt + 1'b1;
            end
        end
    end
    assign bus.out        = state[1];
    assign bus.rise       = rise;
    assign bus.fall       = fall;
    assign bus.glitch_cnt = gcnt;
endmodule

// File: doc/debounce_stage.md
# debounce_stage

Synchronizing debounce stage that cleans a raw, asynchronous logic input before it drives the transistor-level inverter cell (`device`) through the `inp` pin.
- A two-flop synchronizer feeds a persistence counter.
- The stage changes its output level only after the input has held a new value for a programmable number of consecutive clocks.
- It also emits one-cycle edge pulses and counts rejected glitches for diagnostics.

## Interface
- STABLE_CYCLES, default 4: consecutive synchronized cycles a new level must persist before `out` follows it. Legal range 1..255; elaboration fails outside it.
- CNT_W, default 8: width of `glitch_cnt`.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to `clk` at the system level.
- inp  input  1  raw asynchronous level (switch/pad); no timing relation to `clk`.
- out  output  1  debounced level; connects to `device.inp`.
- rise  output  1  one-cycle pulse, high in the cycle `out` first reads 1.
- fall  output  1  one-cycle pulse, high in the cycle `out` first reads 0.
- glitch_cnt  output  CNT_W  saturating count of rejected transitions.

## Operation
- Synchronizer: `s1 <= inp`, `s2 <= s1`. Only `s2` is used downstream. Both reset to 0.
- Persistence counter `cnt` has width ceil(log2(STABLE_CYCLES+1)) and resets to 0.
- Each rising edge, exactly one of the following applies:
  - `s2 != out` and `cnt == STABLE_CYCLES-1` (accept): `out <= s2`, `cnt <= 0`, assert `rise` (if s2=1) or `fall` (if s2=0) in the same update.
  - `s2 != out`, otherwise (qualify): `cnt <= cnt+1`.
  - `s2 == out` and `cnt != 0` (reject): `cnt <= 0`, `glitch_cnt <= glitch_cnt+1` unless already all-ones.
  - `s2 == out` and `cnt == 0` (idle): hold.
- Equivalent FSM view, with states encoded by {out, cnt==0}:
  - STABLE_LOW -> WAIT_HIGH on s2=1.
  - WAIT_HIGH -> STABLE_HIGH on accept; WAIT_HIGH -> STABLE_LOW on reject.
  - STABLE_HIGH and WAIT_LOW are symmetric.
- `rise`/`fall` are registered and last exactly one cycle. They are never both high and never high in consecutive cycles unless STABLE_CYCLES=1 and `s2` toggles every cycle.
- `glitch_cnt` saturates at 2^CNT_W-1 and never wraps. It clears only on reset.
- Reset values: `out`=0, `rise`=0, `fall`=0, `glitch_cnt`=0, `s1`=`s2`=0, `cnt`=0.
- Reset mid-qualification discards progress. After release, `inp` held high re-qualifies from zero.
- Input already high at reset release: treated as a fresh low->high transition and produces `rise`.

## Timing
- Latency: an `inp` change sampled at edge N appears in `s2` after edge N+1. `out`/`rise`/`fall` update at edge N+1+STABLE_CYCLES.
  - Example: default STABLE_CYCLES=4, `inp` stable from edge 1 → `out` changes at edge 6.
- Minimum accepted pulse width: STABLE_CYCLES clocks of stable `s2`.
- A pulse of `s2` lasting k < STABLE_CYCLES cycles is rejected. `glitch_cnt` increments at the edge where `s2` returns, i.e. k+1 edges after the pulse first reaches `s2`.
- Flip at the accept edge (`s2` changes back in the same cycle `cnt` reaches STABLE_CYCLES-1): the decision uses the `s2` value present before that edge.
  - If that pre-edge `s2` still differs from `out`, the transition is accepted.
  - The reverted value then starts a new qualification from `cnt`=0.
- All outputs are registered; no combinational path from `inp` to any output.
- Downstream inverter output equals ~`out`, settling in the same cycle as `out` (zero-delay switch model).

## Test plan
- Reset: hold `rst_n`=0 with `inp` toggling every cycle for 10 cycles → `out`=0, `rise`=`fall`=0, `glitch_cnt`=0 throughout. Assert `rst_n` low asynchronously mid-cycle → outputs clear before the next edge.
- Clean step, STABLE_CYCLES=4: `inp` 0→1 before edge 1, held → `out`=1 and `rise`=1 at edge 6 only, `rise`=0 at edge 7, `device.out`=0. Then `inp` 1→0 → `fall` pulse 6 edges later.
- Glitch rejection: `inp` high for 3 cycles then low → `out` stays 0, `glitch_cnt`=1. Repeat 5 times → `glitch_cnt`=5, no `rise`.
- Boundary: `inp` high for exactly 4 cycles → accepted (`out`=1, one `rise`). Then 4 low cycles → `out`=0, one `fall`, `glitch_cnt` unchanged.
- Saturation: CNT_W=2, inject 6 glitches → `glitch_cnt` reads 1,2,3,3,3,3.
- Reset mid-qualification: `inp` high, pulse `rst_n` low after 3 edges, keep `inp` high → `out`=1 exactly STABLE_CYCLES+2 edges after `rst_n` release, with one `rise`.
